regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the pipeline writeback (WB) stage and the multi-cycle multiply/divide unit (MDU).
- Keeps a per-register busy scoreboard for MDU destinations and raises the ID-stage stall on RAW and WAW hazards against them.
- Sits between the WB stage, the MDU result interface and reg_file. Drives reg_file's wen/waddr/wdata directly.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Defaults match the reg_file widths.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 5;
  localparam int unsigned RegZero   = 0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StForce = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of WB, MDU, ID and reg_file signals around the write-port arbiter.
// The arbiter uses the slave view; its environment uses the master view.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned ADDR_WIDTH = AddrWidth
);
  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_waddr;
  logic [DATA_WIDTH-1:0] wb_wdata;
  logic                  mdu_issue;
  logic [ADDR_WIDTH-1:0] mdu_issue_waddr;
  logic                  mdu_rvalid;
  logic                  mdu_rready;
  logic [ADDR_WIDTH-1:0] mdu_waddr;
  logic [DATA_WIDTH-1:0] mdu_wdata;
  logic [ADDR_WIDTH-1:0] id_raddr1;
  logic [ADDR_WIDTH-1:0] id_raddr2;
  logic                  id_wen;
  logic [ADDR_WIDTH-1:0] id_waddr;
  logic                  id_stall;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [NREG-1:0]       busy_vec;

  modport master (
    output wb_valid, wb_waddr, wb_wdata, mdu_issue, mdu_issue_waddr,
    output mdu_rvalid, mdu_waddr, mdu_wdata, id_raddr1, id_raddr2, id_wen, id_waddr,
    input  mdu_rready, id_stall, rf_wen, rf_waddr, rf_wdata, busy_vec
  );

  modport slave (
    input  wb_valid, wb_waddr, wb_wdata, mdu_issue, mdu_issue_waddr,
    input  mdu_rvalid, mdu_waddr, mdu_wdata, id_raddr1, id_raddr2, id_wen, id_waddr,
    output mdu_rready, id_stall, rf_wen, rf_waddr, rf_wdata, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending MDU destinations and the ID-stage hazard compare.
// A same-cycle set and clear of one register leaves it busy.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  localparam int unsigned NREG      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  output logic [NREG-1:0]       busy_o,
  output logic                  hazard_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    busy_d[RegZero] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // Bit 0 is never set, so the WAW term needs no explicit x0 guard.
  assign hazard_o = (busy_q[raddr1_i] && (raddr1_i != ADDR_WIDTH'(RegZero))) ||
                    (busy_q[raddr2_i] && (raddr2_i != ADDR_WIDTH'(RegZero))) ||
                    (wen_i && busy_q[waddr_i]);
  assign busy_o   = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the reg_file write port between WB and a one-entry MDU result buffer,
// forcing a drain via ID stall when the buffer has waited too long.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DataWidth,
  parameter int unsigned ADDR_WIDTH   = AddrWidth,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rstn,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned CntW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT - 1);

  arb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  logic [CntW-1:0]       starve_q;

  logic wb_eff, buf_held, drain, sb_hazard;

  assign wb_eff   = bus.wb_valid && (bus.wb_waddr != ADDR_WIDTH'(RegZero));
  assign buf_held = (state_q == StFull) || (state_q == StForce);
  assign drain    = buf_held && !wb_eff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StEmpty;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      starve_q   <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (bus.mdu_rvalid) begin
            buf_addr_q <= bus.mdu_waddr;
            buf_data_q <= bus.mdu_wdata;
            starve_q   <= '0;
            state_q    <= StFull;
          end
        end
        StFull: begin
          if (drain)                  state_q  <= StEmpty;
          else if (starve_q == CntMax) state_q <= StForce;
          else                        starve_q <= starve_q + 1'b1;
        end
        StForce: begin
          if (drain) state_q <= StEmpty;
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Reset gates every output so they drop as soon as rstn falls.
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (rstn) begin
      if (wb_eff) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = bus.wb_waddr;
        bus.rf_wdata = bus.wb_wdata;
      end else if (buf_held && (buf_addr_q != ADDR_WIDTH'(RegZero))) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = buf_addr_q;
        bus.rf_wdata = buf_data_q;
      end
    end
  end

  assign bus.mdu_rready = rstn && (state_q == StEmpty);
  assign bus.id_stall   = rstn && ((state_q == StForce) || sb_hazard);

  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .set_i      (bus.mdu_issue),
    .set_addr_i (bus.mdu_issue_waddr),
    .clr_i      (drain),
    .clr_addr_i (buf_addr_q),
    .raddr1_i   (bus.id_raddr1),
    .raddr2_i   (bus.id_raddr2),
    .wen_i      (bus.id_wen),
    .waddr_i    (bus.id_waddr),
    .busy_o     (bus.busy_vec),
    .hazard_o   (sb_hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected reg_file writes are queued by the
// stimulus and checked by a negedge monitor; state outputs are checked inline.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wb_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every rf write must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.rf_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: got unexpected r%0d=%0h required none",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (bus.rf_waddr !== w.a || bus.rf_wdata !== w.d) begin
          errors++;
          $display("FAIL rf_write: got r%0d=%0h required r%0d=%0h",
                   bus.rf_waddr, bus.rf_wdata, w.a, w.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wb_valid = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h33;
    bus.mdu_issue = 1'b0; bus.mdu_issue_waddr = '0;
    bus.mdu_rvalid = 1'b0; bus.mdu_waddr = '0; bus.mdu_wdata = '0;
    bus.id_raddr1 = '0; bus.id_raddr2 = '0; bus.id_wen = 1'b0; bus.id_waddr = '0;

    // Reset held for three cycles; outputs stay low even with WB active.
    repeat (3) cyc();
    settle();
    chk("rst_rf_wen_in_reset", 64'(bus.rf_wen), 64'd0);
    chk("rst_rready_in_reset", 64'(bus.mdu_rready), 64'd0);
    bus.wb_valid = 1'b0;
    cyc();
    rstn = 1'b1;
    settle();
    chk("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("rst_id_stall", 64'(bus.id_stall), 64'd0);
    chk("rst_rready", 64'(bus.mdu_rready), 64'd1);

    // Idle port: issue r5, result in cycle 4, write in cycle 5.
    cyc();
    bus.mdu_issue = 1'b1; bus.mdu_issue_waddr = 5'd5;
    cyc();
    bus.mdu_issue = 1'b0;
    settle();
    chk("idle_busy5_c2", 64'(bus.busy_vec[5]), 64'd1);
    cyc();
    bus.id_raddr2 = 5'd5;
    settle();
    chk("raw_stall_r5", 64'(bus.id_stall), 64'd1);
    bus.id_raddr2 = '0; bus.id_wen = 1'b1; bus.id_waddr = '0;
    settle();
    chk("raw_x0_no_stall", 64'(bus.id_stall), 64'd0);
    cyc();
    bus.id_wen = 1'b0;
    bus.mdu_rvalid = 1'b1; bus.mdu_waddr = 5'd5; bus.mdu_wdata = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    settle();
    chk("idle_busy5_c4", 64'(bus.busy_vec[5]), 64'd1);
    cyc();
    bus.mdu_rvalid = 1'b0;
    settle();
    chk("idle_busy5_c5", 64'(bus.busy_vec[5]), 64'd1);
    chk("idle_rready_full", 64'(bus.mdu_rready), 64'd0);
    cyc();
    settle();
    chk("idle_busy5_c6", 64'(bus.busy_vec[5]), 64'd0);
    chk("idle_rready_c6", 64'(bus.mdu_rready), 64'd1);

    // Contention: WB writes r3 every cycle while r7 waits in the buffer.
    cyc();
    bus.mdu_rvalid = 1'b1; bus.mdu_waddr = 5'd7; bus.mdu_wdata = 32'h11;
    bus.wb_valid = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h33;
    push(5'd3, 32'h33);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.mdu_rvalid = 1'b0;
      push(5'd3, 32'h33);
      settle();
      chk($sformatf("starve_full%0d_stall", i), 64'(bus.id_stall), 64'd0);
    end
    cyc();
    push(5'd3, 32'h33);
    settle();
    chk("starve_force_stall", 64'(bus.id_stall), 64'd1);
    chk("starve_force_rready", 64'(bus.mdu_rready), 64'd0);
    cyc();
    bus.wb_valid = 1'b0;
    push(5'd7, 32'h11);
    settle();
    chk("starve_drain_stall", 64'(bus.id_stall), 64'd1);
    cyc();
    settle();
    chk("starve_after_stall", 64'(bus.id_stall), 64'd0);
    chk("starve_after_rready", 64'(bus.mdu_rready), 64'd1);

    // x0: WB write to r0 lets the buffer drain; issue to r0 sets nothing.
    cyc();
    bus.mdu_rvalid = 1'b1; bus.mdu_waddr = 5'd9; bus.mdu_wdata = 32'h22;
    cyc();
    bus.mdu_rvalid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'hFFFF;
    bus.mdu_issue = 1'b1; bus.mdu_issue_waddr = 5'd0;
    push(5'd9, 32'h22);
    cyc();
    bus.wb_valid = 1'b0; bus.mdu_issue = 1'b0;
    settle();
    chk("x0_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("x0_rready", 64'(bus.mdu_rready), 64'd1);

    // Same-cycle set and clear of r4: set wins.
    cyc();
    bus.mdu_issue = 1'b1; bus.mdu_issue_waddr = 5'd4;
    cyc();
    bus.mdu_issue = 1'b0;
    bus.mdu_rvalid = 1'b1; bus.mdu_waddr = 5'd4; bus.mdu_wdata = 32'h44;
    cyc();
    bus.mdu_rvalid = 1'b0;
    bus.mdu_issue = 1'b1; bus.mdu_issue_waddr = 5'd4;
    push(5'd4, 32'h44);
    cyc();
    bus.mdu_issue = 1'b0;
    settle();
    chk("setclr_busy4", 64'(bus.busy_vec[4]), 64'd1);

    // Asynchronous reset between edges while r6 sits in the buffer.
    cyc();
    bus.mdu_issue = 1'b1; bus.mdu_issue_waddr = 5'd6;
    cyc();
    bus.mdu_issue = 1'b0;
    bus.mdu_rvalid = 1'b1; bus.mdu_waddr = 5'd6; bus.mdu_wdata = 32'h66;
    bus.wb_valid = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h33;
    push(5'd3, 32'h33);
    cyc();
    bus.mdu_rvalid = 1'b0;
    bus.id_raddr1 = 5'd6;
    #1 rstn = 1'b0;
    #1;
    chk("arst_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("arst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("arst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("arst_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("arst_rready", 64'(bus.mdu_rready), 64'd0);
    chk("arst_id_stall", 64'(bus.id_stall), 64'd0);
    bus.wb_valid = 1'b0;
    bus.id_raddr1 = '0;
    cyc();
    rstn = 1'b1;
    cyc();
    settle();
    chk("arst_no_drain", 64'(bus.rf_wen), 64'd0);
    chk("arst_rready_after", 64'(bus.mdu_rready), 64'd1);
    chk("arst_busy_after", 64'(bus.busy_vec), 64'd0);

    cyc();
    cyc();
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
